// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI-flash responder and the flash reader:
// opcodes, address length and responder state encoding.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  localparam int ADDR_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with registered rise/fall
// strobes. Pin edge to strobe latency is STAGES+1 clk.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= level_o;
      rise_q <= level_o & ~prev_q;
      fall_q <= ~level_o & prev_q;
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target answering READ, RDSR1 and RDID from an on-chip
// memory with a one-cycle synchronous read port; pins oversampled in clk.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | deselected, waiting for cs_n to fall
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 3 address bytes (READ only)
// ST_DATA   | driving response bytes on sdo, sdo_oe high
// ST_IGNORE | unsupported opcode, bus released until cs_n rises
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  input  logic              busy_i,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              xfer_done
);

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl;
  logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

  // Synchronizers reset to "selected/low" so a reset released in the middle
  // of a transfer never sees a cs_n fall and stays idle until a fresh select.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (sck),
    .level_o (sck_lvl_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (sdi),
    .level_o (sdi_lvl),
    .rise_o  (sdi_rise_unused),
    .fall_o  (sdi_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        shin_q, shin_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        shout_q, shout_d;
  logic [7:0]        pref_q, pref_d;
  logic              rd_pend_q, rd_pend_d;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr_shift;
  logic [7:0]        opcode;
  logic [7:0]        load_byte;
  logic              done_pulse;

  assign addr_shift = {addr_q[ADDR_W-2:0], sdi_lvl};
  assign opcode     = {shin_q, sdi_lvl};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    shin_d     = shin_q;
    op_d       = op_q;
    shout_d    = shout_q;
    pref_d     = rd_pend_q ? mem_rdata : pref_q;
    rd_req     = 1'b0;
    rd_addr    = addr_q;
    load_byte  = 8'h00;
    done_pulse = 1'b0;

    if (cs_rise) begin
      // Deselect wins over any sck edge in the same cycle; an in-flight
      // memory read is dropped by not capturing it.
      state_d    = ST_IDLE;
      pref_d     = pref_q;
      done_pulse = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d    = ST_CMD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            shout_d    = 8'h00;
          end
        end

        ST_CMD: begin
          if (sck_rise) begin
            shin_d    = opcode[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              op_d       = opcode;
              byte_cnt_d = 2'd0;
              case (opcode)
                OP_READ:           state_d = ST_ADDR;
                OP_RDSR1, OP_RDID: state_d = ST_DATA;
                default:           state_d = ST_IGNORE;
              endcase
            end
          end
        end

        ST_ADDR: begin
          if (sck_rise) begin
            addr_d    = addr_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'(ADDR_BYTES - 1)) begin
                rd_req     = 1'b1;
                rd_addr    = addr_shift;
                addr_d     = addr_shift + ADDR_W'(1);
                byte_cnt_d = 2'd0;
                state_d    = ST_DATA;
              end
            end
          end
        end

        ST_DATA: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
              // Byte boundary: load the next response byte, MSB goes out now.
              case (op_q)
                OP_READ: begin
                  load_byte = pref_q;
                  rd_req    = 1'b1;
                  rd_addr   = addr_q;
                  addr_d    = addr_q + ADDR_W'(1);
                end
                OP_RDSR1: load_byte = {7'b0, busy_i};
                default: begin
                  case (byte_cnt_q)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = 8'h00;
                  endcase
                end
              endcase
              shout_d    = load_byte;
              byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
            end else begin
              shout_d = {shout_q[6:0], 1'b0};
            end
          end
        end

        ST_IGNORE: ;

        default: state_d = ST_IDLE;
      endcase
    end

    rd_pend_d = rd_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      addr_q     <= '0;
      shin_q     <= 7'd0;
      op_q       <= 8'h00;
      shout_q    <= 8'h00;
      pref_q     <= 8'h00;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      shin_q     <= shin_d;
      op_q       <= op_d;
      shout_q    <= shout_d;
      pref_q     <= pref_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign sdo_oe    = (state_q == ST_DATA) && !cs_lvl;
  assign sdo       = sdo_oe & shout_q[7];
  assign mem_rd_en = rd_req;
  assign mem_addr  = rd_addr;
  assign xfer_done = done_pulse;

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI-flash target that answers the serial-flash command set our SPI flash reader issues: single-lane READ (0x03), RDSR1 (0x05) and RDID (0x9F). It serves read data from an on-chip memory through a synchronous read port. It sits behind the board-level SPI pins, or loops back to the flash reader for FPGA-level bring-up without a physical flash. The target runs SPI mode 0 only. SCK, CS_N and SDI are oversampled in the `clk` domain.

## Interface
- `ADDR_W`, 24: flash address width; also the width of `mem_addr`.
- `JEDEC_ID`, 24'hEF4018: the three bytes returned by RDID, MSB first.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `cs_n` and `sdi`.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sck`  in  1  SPI clock from the initiator; asynchronous to `clk`.
- `cs_n`  in  1  chip select, active low.
- `sdi`  in  1  serial data from the initiator.
- `sdo`  out  1  serial data to the initiator.
- `sdo_oe`  out  1  output enable for the `sdo` pad driver.
- `busy_i`  in  1  returned as bit 0 of the RDSR1 status byte (WIP).
- `mem_rd_en`  out  1  single-cycle memory read strobe.
- `mem_addr`  out  ADDR_W  byte address for the memory read.
- `mem_rdata`  in  8  memory data, valid exactly 1 `clk` after `mem_rd_en`.
- `xfer_done`  out  1  1-cycle pulse when `cs_n` deasserts after a selected transfer.

## Operation
- Sampling: `sdi` is shifted in, MSB first, on each detected `sck` rise. Each detected `sck` fall shifts `sdo` to the next bit.
- State machine: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE → CMD on `cs_n` falling edge. Bit and byte counters clear.
  - CMD → after 8 bits. 0x03 → ADDR. 0x05 and 0x9F → DATA. Any other opcode → IGNORE.
  - ADDR collects 3 bytes, MSB first. On the 24th rise it issues `mem_rd_en` with the collected address, then → DATA.
  - DATA drives response bytes. The MSB of each byte appears on the fall after the previous byte's 8th rise.
  - IGNORE keeps `sdo_oe` = 0 until `cs_n` rises.
- READ data:
  - Byte n comes from address A+n.
  - When a byte loads into the shift register, the block prefetches A+n+1 into a holding register.
  - The address wraps modulo 2^ADDR_W, so 0xFFFFFF is followed by 0x000000.
  - Reading continues indefinitely while `cs_n` stays low.
- RDSR1: returns {7'b0, `busy_i`} repeatedly. `busy_i` is sampled when each byte loads.
- RDID: returns the 3 bytes of JEDEC_ID, then 0x00 for every byte after that.
- `sdo_oe` = 1 only in DATA with `cs_n` low. When `sdo_oe` = 0, `sdo` = 0.
- `cs_n` rise, detected in any state:
  - → IDLE the next cycle.
  - `sdo_oe` drops, and any outstanding prefetch is discarded.
  - `xfer_done` pulses if the state was not IDLE.
- Edge precedence: a `cs_n` rise and an `sck` edge in the same cycle count as the `cs_n` rise only.
- Reset values: `sdo` 0, `sdo_oe` 0, `mem_rd_en` 0, `mem_addr` 0, `xfer_done` 0, state IDLE. Reset mid-transfer abandons the transfer without producing `xfer_done`.

## Timing
- Oversampling limits:
  - `sck` high and low phases are each ≥ 4 `clk` periods.
  - `cs_n` setup to the first `sck` rise is ≥ 4 `clk`.
  - Faster `sck` is out of spec, and behaviour in that case is undefined.
- Edge-detect latency is SYNC_STAGES+1 `clk` from the pin edge to the internal strobe.
- First READ byte:
  - `mem_rd_en` fires in the same cycle as the 24th-rise strobe.
  - `mem_rdata` is captured 1 cycle later.
  - The shift register is loaded ≥ 1 cycle before the next fall strobe.
- Each later byte is prefetched within 2 `clk` of the previous byte load. Exactly one `mem_rd_en` pulse is issued per byte.
- `sdo` changes within 1 `clk` of a fall strobe. It is stable well before the following `sck` rise at the pin.
- `xfer_done` fires SYNC_STAGES+1 `clk` after the `cs_n` rise at the pin.

## Structure
- `spi_flash_pkg` holds:
  - opcode constants OP_READ = 8'h03, OP_RDSR1 = 8'h05, OP_RDID = 8'h9F;
  - the state enum;
  - ADDR_BYTES = 3.
- `spi_flash_reader` imports the same package for its opcodes.
- Sub-module `spi_sync_edge`, instantiated three times: an N-stage synchronizer plus registered rise/fall strobes for `sck`, `cs_n` and `sdi`. The `sdi` instance uses only the level output.
- Top level contains the FSM, the 3-bit bit counter, the 2-bit byte counter, the address register, the shift-in and shift-out registers, and the prefetch register.

## Test plan
- READ at 0x000010 for 4 bytes, memory model returns `addr[7:0]` ^ 0x5A:
  - `sdo` yields 0x4A, 0x4B, 0x48, 0x49;
  - `mem_addr` steps 0x10 to 0x13, then one more prefetch to 0x14;
  - one `xfer_done` pulse.
- READ at 0xFFFFFF for 2 bytes → `mem_addr` 0xFFFFFF then 0x000000, data 0xA5 then 0x5A.
- RDID for 4 bytes → 0xEF, 0x40, 0x18, 0x00.
- RDSR1 for 2 bytes, `busy_i` = 1 for the first byte and 0 after → 0x01 then 0x00.
- Unknown opcode 0xAB followed by 16 clocks → `sdo_oe` stays 0 and there is no `mem_rd_en`. The next READ at 0x000000 still returns 0x5A.
- `cs_n` raised after 12 address bits, then a READ at 0x000020 → no `mem_rd_en` from the aborted transfer, data 0x7A.
- `rst_n` pulsed mid-DATA → all outputs return to reset values and no `xfer_done`. The next READ at 0x000020 still returns 0x7A.
